// File: rtl/aer_channel_arbiter.sv
// aer_channel_arbiter
//   Shares one AER transmitter between NUM_CH channel requesters. Grants one channel at a
//   time (round-robin), drives its address/direction onto the shared bus, sequences the
//   transmitter handshake (go -> Fs_sen -> Fe_d) and then completes a 4-phase release with
//   the requester.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   Req[N]       per-channel request level, held until release
//   Down[N]      per-channel direction (1=down), valid while Req high
//   Fs_sen       transmitter accepted event (level)
//   Fe_d         transmitter finished event (level)
//   Gnt[N]       one-hot grant (registered)
//   go           start request to transmitter (registered)
//   Addr[CH_W]   granted channel index, held until the next grant
//   Dir          latched Down of granted channel
//   busy         high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse on a handshake timeout abort

module aer_channel_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] Req,
    input  logic [NUM_CH-1:0] Down,
    input  logic              Fs_sen,
    input  logic              Fe_d,
    output logic [NUM_CH-1:0] Gnt,
    output logic              go,
    output logic [CH_W-1:0]   Addr,
    output logic              Dir,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StSend,
        StWaitDone,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              go_q, go_d;
    logic [CH_W-1:0]   addr_q, addr_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]  sel;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              timeout_hit;

    // Addr doubles as the record of which channel owns the transmitter.
    assign sel = addr_q[IDX_W-1:0];

    // cnt_q counts cycles already waited; the abort fires on the TIMEOUT-th waited cycle.
    assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));

    // Round-robin pick: first set Req bit searching upward from ptr+1, wrapping.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] idx_n;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_n      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_n = IDX_W'(idx);
            if (!pick_valid && Req[idx_n]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_n;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        go_d    = go_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d          = StGrant;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    addr_d           = CH_W'(pick_idx);
                    dir_d            = Down[pick_idx];
                end
            end
            StGrant: begin
                if (Req[sel]) begin
                    state_d = StSend;
                    go_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    // Requester withdrew before go: abandon without moving the pointer.
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            StSend: begin
                if (Fs_sen) begin
                    go_d  = 1'b0;
                    cnt_d = '0;
                    if (Fe_d) begin
                        state_d = StRelease;
                        gnt_d   = '0;
                    end else begin
                        state_d = StWaitDone;
                    end
                end else if (timeout_hit) begin
                    state_d = StRelease;
                    go_d    = 1'b0;
                    gnt_d   = '0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StWaitDone: begin
                if (Fe_d) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StRelease: begin
                gnt_d = '0;
                go_d  = 1'b0;
                if (!Req[sel] && !Fe_d) begin
                    state_d = StIdle;
                    ptr_d   = sel;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                go_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            go_q    <= 1'b0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            ptr_q   <= IDX_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            go_q    <= go_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Gnt         = gnt_q;
    assign go          = go_q;
    assign Addr        = addr_q;
    assign Dir         = dir_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule
